// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_pkg
// Description : Shared state encoding and default widths/latency for TPU blocks
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

    localparam int c_ADDRESSSIZE = 10;
    localparam int c_ROWS_BW     = 10;
    localparam int c_TILES_BW    = 4;
    localparam int c_PIPE_LAT    = 17;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_W = 3'd1,
        S_POP_W  = 3'd2,
        S_LOAD_W = 3'd3,
        S_STREAM = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/tpu_valid_delay.sv
`default_nettype none
// ============================================================================
// Module      : tpu_valid_delay
// Description : DEPTH-cycle shift of a valid strobe with synchronous flush
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_valid_delay #(
    parameter int DEPTH = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_valid,
    output logic o_valid
);

    logic [DEPTH-1:0] r_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
        end else begin
            r_shift <= {r_shift[DEPTH-2:0], i_valid};
        end
    end

    assign o_valid = r_shift[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/tpu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tpu_tile_sequencer
// Description : Per-tile weight load, UB streaming and result write sequencing
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_tile_sequencer
    import tpu_pkg::*;
#(
    parameter int ADDRESSSIZE = c_ADDRESSSIZE,
    parameter int ROWS_BW     = c_ROWS_BW,
    parameter int TILES_BW    = c_TILES_BW,
    parameter int PIPE_LAT    = c_PIPE_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [ROWS_BW-1:0]     i_num_rows,
    input  logic [TILES_BW-1:0]    i_num_tiles,
    input  logic [ADDRESSSIZE-1:0] i_src_base,
    input  logic [ADDRESSSIZE-1:0] i_dst_base,
    input  logic                   i_fifo_empty,
    output logic                   o_fifo_read_enable,
    output logic                   o_we_rl,
    output logic [ADDRESSSIZE-1:0] o_ub_address,
    output logic                   o_ub_rd_valid,
    output logic                   o_res_write_enable,
    output logic [ADDRESSSIZE-1:0] o_res_address,
    output logic                   o_busy,
    output logic                   o_end,
    output logic                   o_error
);

    seq_state_t             r_state;
    logic [ROWS_BW-1:0]     r_num_rows;
    logic [TILES_BW-1:0]    r_num_tiles;
    logic [TILES_BW-1:0]    r_tile_cnt;
    logic [ROWS_BW-1:0]     r_row_cnt;
    logic [ROWS_BW-1:0]     r_wr_cnt;
    logic [ADDRESSSIZE-1:0] r_src_ptr;
    logic [ADDRESSSIZE-1:0] r_dst_ptr;
    logic                   r_pop;
    logic                   r_we_rl;
    logic                   r_ub_valid;
    logic [ADDRESSSIZE-1:0] r_ub_addr;
    logic                   r_end;
    logic                   r_err;

    logic                   w_res_we;
    logic                   w_last_wr;

    // Result strobes are the UB read strobes replayed PIPE_LAT cycles later.
    tpu_valid_delay #(
        .DEPTH (PIPE_LAT)
    ) u_wr_delay (
        .clk     (clk),
        .rst     (rst),
        .i_clear (i_abort),
        .i_valid (r_ub_valid),
        .o_valid (w_res_we)
    );

    assign w_last_wr = (r_wr_cnt == r_num_rows - ROWS_BW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_num_rows  <= '0;
            r_num_tiles <= '0;
            r_tile_cnt  <= '0;
            r_row_cnt   <= '0;
            r_wr_cnt    <= '0;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_pop       <= 1'b0;
            r_we_rl     <= 1'b0;
            r_ub_valid  <= 1'b0;
            r_ub_addr   <= '0;
            r_end       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pop      <= 1'b0;
            r_we_rl    <= 1'b0;
            r_ub_valid <= 1'b0;
            r_ub_addr  <= '0;
            r_end      <= 1'b0;
            r_err      <= 1'b0;
            if (w_res_we) begin
                r_dst_ptr <= r_dst_ptr + ADDRESSSIZE'(1);
                r_wr_cnt  <= r_wr_cnt + ROWS_BW'(1);
            end
            if (i_abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            if ((i_num_rows != '0) && (i_num_tiles != '0)) begin
                                r_num_rows  <= i_num_rows;
                                r_num_tiles <= i_num_tiles;
                                r_src_ptr   <= i_src_base;
                                r_dst_ptr   <= i_dst_base;
                                r_tile_cnt  <= '0;
                                r_state     <= S_WAIT_W;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_WAIT_W: begin
                        if (!i_fifo_empty) begin
                            r_pop   <= 1'b1;
                            r_state <= S_POP_W;
                        end
                    end
                    S_POP_W: begin
                        r_we_rl <= 1'b1;
                        r_state <= S_LOAD_W;
                    end
                    S_LOAD_W: begin
                        r_ub_valid <= 1'b1;
                        r_ub_addr  <= r_src_ptr;
                        r_src_ptr  <= r_src_ptr + ADDRESSSIZE'(1);
                        r_row_cnt  <= ROWS_BW'(1);
                        r_wr_cnt   <= '0;
                        r_state    <= S_STREAM;
                    end
                    S_STREAM: begin
                        // r_row_cnt counts the read currently on the UB port.
                        if (r_row_cnt == r_num_rows) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_ub_valid <= 1'b1;
                            r_ub_addr  <= r_src_ptr;
                            r_src_ptr  <= r_src_ptr + ADDRESSSIZE'(1);
                            r_row_cnt  <= r_row_cnt + ROWS_BW'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (w_res_we && w_last_wr) begin
                            r_tile_cnt <= r_tile_cnt + TILES_BW'(1);
                            if (r_tile_cnt + TILES_BW'(1) == r_num_tiles) begin
                                r_end   <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_WAIT_W;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_fifo_read_enable = r_pop;
    assign o_we_rl            = r_we_rl;
    assign o_ub_rd_valid      = r_ub_valid;
    assign o_ub_address       = r_ub_addr;
    assign o_res_write_enable = w_res_we;
    assign o_res_address      = w_res_we ? r_dst_ptr : '0;
    assign o_busy             = (r_state != S_IDLE);
    assign o_end              = r_end;
    assign o_error            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tpu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tpu_tile_sequencer
// Description : Scoreboard bench for tpu_tile_sequencer (directed + random jobs)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpu_tile_sequencer;

    localparam int PIPE_LAT = 17;
    localparam int AMASK    = 1023;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [9:0] num_rows;
    logic [3:0] num_tiles;
    logic [9:0] src_base;
    logic [9:0] dst_base;
    logic       fifo_empty;
    logic       fifo_read_enable;
    logic       we_rl;
    logic [9:0] ub_address;
    logic       ub_rd_valid;
    logic       res_write_enable;
    logic [9:0] res_address;
    logic       busy;
    logic       end_;
    logic       error;

    tpu_tile_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .i_start            (start),
        .i_abort            (abort),
        .i_num_rows         (num_rows),
        .i_num_tiles        (num_tiles),
        .i_src_base         (src_base),
        .i_dst_base         (dst_base),
        .i_fifo_empty       (fifo_empty),
        .o_fifo_read_enable (fifo_read_enable),
        .o_we_rl            (we_rl),
        .o_ub_address       (ub_address),
        .o_ub_rd_valid      (ub_rd_valid),
        .o_res_write_enable (res_write_enable),
        .o_res_address      (res_address),
        .o_busy             (busy),
        .o_end              (end_),
        .o_error            (error)
    );

    int unsigned exp_rd[$];
    int unsigned exp_wr[$];
    int unsigned rd_times[$];
    int          exp_pop;
    int          exp_end;
    int          exp_err;
    int          ends_seen;
    int unsigned cyc;
    int          n_vec;
    int          n_mis;
    logic        prev_fe;
    logic        prev_pop;
    logic        prev_rl;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name, input int unsigned act);
        n_vec++;
        n_mis++;
        $display("FAIL %s: got %0h with nothing expected at cycle %0d", name, act, cyc);
    endtask

    // Monitor: pops the expected stream whenever the DUT presents an event.
    always @(negedge clk) begin
        if (ub_rd_valid) begin
            if (exp_rd.size() == 0) fail_evt("unexpected_read", ub_address);
            else chk("ub_address", ub_address, exp_rd.pop_front());
            rd_times.push_back(cyc);
        end
        if (res_write_enable) begin
            if (exp_wr.size() == 0) fail_evt("unexpected_write", res_address);
            else chk("res_address", res_address, exp_wr.pop_front());
            if (rd_times.size() == 0) fail_evt("write_without_read", res_address);
            else chk("write_latency", cyc - rd_times.pop_front(), PIPE_LAT);
        end
        if (fifo_read_enable) begin
            if (exp_pop == 0) fail_evt("unexpected_pop", 1);
            else exp_pop--;
            chk("pop_with_writes_pending", rd_times.size(), 0);
            chk("pop_after_fifo_nonempty", prev_fe, 0);
        end
        if (we_rl) chk("reload_follows_pop", prev_pop, 1);
        if (prev_rl) chk("stream_follows_reload", ub_rd_valid, 1);
        if (end_) begin
            if (exp_end == 0) fail_evt("unexpected_end", 1);
            else exp_end--;
            chk("writes_left_at_end", exp_wr.size(), 0);
            ends_seen++;
        end
        if (error) begin
            if (exp_err == 0) fail_evt("unexpected_error", 1);
            else exp_err--;
        end
        prev_fe  = fifo_empty;
        prev_pop = fifo_read_enable;
        prev_rl  = we_rl;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_rd.delete();
        exp_wr.delete();
        rd_times.delete();
        exp_pop = 0;
        exp_end = 0;
    endtask

    task automatic launch_job(input int rows, input int tiles, input int src, input int dst);
        for (int k = 0; k < tiles; k++) begin
            for (int i = 0; i < rows; i++) begin
                exp_rd.push_back((src + k * rows + i) & AMASK);
                exp_wr.push_back((dst + k * rows + i) & AMASK);
            end
        end
        exp_pop += tiles;
        exp_end += 1;
        num_rows  = rows[9:0];
        num_tiles = tiles[3:0];
        src_base  = src[9:0];
        dst_base  = dst[9:0];
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_end(input int target, input bit rnd_fifo);
        int n = 0;
        while (ends_seen < target && n < 3000) begin
            tick();
            if (rnd_fifo) fifo_empty = 1'($urandom_range(0, 1));
            n++;
        end
        fifo_empty = 1'b0;
        if (ends_seen < target) fail_evt("end_timeout", n);
        tick();
        chk("busy_after_end", busy, 0);
        chk("reads_left", exp_rd.size(), 0);
        chk("writes_left", exp_wr.size(), 0);
        chk("pops_left", exp_pop, 0);
    endtask

    task automatic run_job(input int rows, input int tiles, input int src, input int dst, input bit rnd);
        int target;
        target = ends_seen + 1;
        launch_job(rows, tiles, src, dst);
        wait_end(target, rnd);
    endtask

    task automatic wait_read();
        int n = 0;
        while (!ub_rd_valid && n < 200) begin
            tick();
            n++;
        end
        if (!ub_rd_valid) fail_evt("read_timeout", n);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ub_rd_valid"}, ub_rd_valid, 0);
        chk({tag, "_res_we"}, res_write_enable, 0);
        chk({tag, "_pop"}, fifo_read_enable, 0);
        chk({tag, "_we_rl"}, we_rl, 0);
        chk({tag, "_end"}, end_, 0);
        chk({tag, "_addrs"}, {ub_address, res_address}, 0);
    endtask

    initial begin
        int target;
        rst = 1'b0; start = 1'b0; abort = 1'b0; fifo_empty = 1'b0;
        num_rows = '0; num_tiles = '0; src_base = '0; dst_base = '0;
        exp_pop = 0; exp_end = 0; exp_err = 0; ends_seen = 0; cyc = 0;
        n_vec = 0; n_mis = 0;
        #1 rst = 1'b1;
        #2 check_idle_outputs("reset");
        chk("reset_error", error, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single tile, then multi-tile contiguous streams, then address wrap.
        run_job(8, 1, 'h010, 'h020, 0);
        run_job(4, 3, 0, 'h100, 0);
        run_job(4, 1, 'h3FE, 'h3FD, 0);

        // Weight FIFO empty for 5 cycles after start.
        fifo_empty = 1'b1;
        target = ends_seen + 1;
        launch_job(2, 1, 'h040, 'h050);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_while_fifo_empty", busy, 1);
            chk("no_pop_while_fifo_empty", fifo_read_enable, 0);
        end
        fifo_empty = 1'b0;
        tick();
        chk("pop_after_fifo_ready", fifo_read_enable, 1);
        wait_end(target, 0);

        // Rejected starts with zero rows / zero tiles.
        num_rows = 10'd0; num_tiles = 4'd2; exp_err++;
        start = 1'b1; tick(); start = 1'b0;
        chk("error_pulse_rows0", error, 1);
        chk("busy_rows0", busy, 0);
        num_rows = 10'd3; num_tiles = 4'd0; exp_err++;
        start = 1'b1; tick(); start = 1'b0;
        chk("error_pulse_tiles0", error, 1);
        tick();
        chk("error_one_cycle", error, 0);
        chk("errors_left", exp_err, 0);

        // Starts during STREAM are ignored.
        target = ends_seen + 1;
        launch_job(10, 1, 'h200, 'h300);
        wait_read();
        tick();
        num_rows = 10'd0; start = 1'b1; tick(); start = 1'b0;
        num_rows = 10'd5; src_base = 10'h155; start = 1'b1; tick(); start = 1'b0;
        wait_end(target, 0);

        // Abort during DRAIN.
        launch_job(4, 1, 'h080, 'h090);
        wait_read();
        while (ub_rd_valid) tick();
        tick(); tick();
        abort = 1'b1; tick(); abort = 1'b0;
        clear_model();
        check_idle_outputs("after_abort");
        repeat (25) tick();

        // Abort and start in the same IDLE cycle.
        num_rows = 10'd3; num_tiles = 4'd1; abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_beats_start", busy, 0);
        repeat (10) tick();

        // Asynchronous reset mid-STREAM, then a fresh job.
        launch_job(12, 2, 'h0A0, 'h0B0);
        wait_read();
        tick(); tick();
        #2 rst = 1'b1;
        #1 check_idle_outputs("async_reset");
        clear_model();
        tick(); tick();
        rst = 1'b0;
        repeat (25) tick();
        run_job(5, 1, 'h001, 'h002, 0);

        // Randomized jobs with a randomly stalling weight FIFO.
        for (int t = 0; t < 8; t++) begin
            run_job(int'($urandom_range(1, 24)), int'($urandom_range(1, 3)),
                    int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1);
        end

        chk("final_end_count", exp_end, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tpu_tile_sequencer.md
TPU_TILE_SEQUENCER -- requirements
Module: tpu_tile_sequencer

Interface
REQ-001 Parameters SHALL be ADDRESSSIZE=10 (UB/result address width), ROWS_BW=10 (row-count width), TILES_BW=4 (tile-count width), PIPE_LAT=17 (cycles from UB address issue to deskewed result valid; >=2).
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  pulse; launches a job when in IDLE.
REQ-005 abort  in  1  synchronous; forces IDLE from any state.
REQ-006 num_rows  in  ROWS_BW  input rows per tile; sampled on accepted start.
REQ-007 num_tiles  in  TILES_BW  tiles per job; sampled on accepted start.
REQ-008 src_base, dst_base  in  ADDRESSSIZE each  UB read base and result-SRAM write base; sampled on accepted start.
REQ-009 fifo_empty  in  1  weight FIFO empty flag.
REQ-010 fifo_read_enable  out  1  pops one weight tile.
REQ-011 we_rl  out  1  weight reload strobe to the systolic array.
REQ-012 ub_address  out  ADDRESSSIZE  UB read address; ub_rd_valid  out  1  address valid.
REQ-013 res_write_enable  out  1; res_address  out  ADDRESSSIZE  result SRAM write port.
REQ-014 busy  out  1  high in any non-IDLE state; end_  out  1  one-cycle job-complete pulse; error  out  1  one-cycle pulse on rejected start.

Function
REQ-015 States SHALL be IDLE, WAIT_W, POP_W, LOAD_W, STREAM, DRAIN, DONE.
REQ-016 IDLE: start with num_rows!=0 and num_tiles!=0 -> WAIT_W, latch inputs, tile counter=0; start with either zero -> error=1 next cycle, stay IDLE.
REQ-017 WAIT_W: remain while fifo_empty=1; fifo_empty=0 -> POP_W.
REQ-018 POP_W: fifo_read_enable=1 for exactly this cycle -> LOAD_W.
REQ-019 LOAD_W: we_rl=1 for exactly this cycle -> STREAM.
REQ-020 STREAM: exactly num_rows cycles, ub_rd_valid=1, ub_address=src_ptr+i (i=0..num_rows-1) -> DRAIN.
REQ-021 src_ptr SHALL start at src_base and persist across tiles (tile k reads src_base+k*num_rows+i); likewise dst_ptr from dst_base.
REQ-022 res_write_enable SHALL assert for num_rows consecutive cycles beginning exactly PIPE_LAT cycles after the first ub_rd_valid of the tile; res_address=dst_ptr+j on write j.
REQ-023 DRAIN: exit after last result write; tile counter+1; if counter==num_tiles -> DONE, else -> WAIT_W.
REQ-024 DONE: end_=1 for one cycle -> IDLE.
REQ-025 All address arithmetic SHALL wrap modulo 2^ADDRESSSIZE without error.
REQ-026 start while busy SHALL be ignored (no error, no relatch).
REQ-027 abort SHALL take priority over all transitions: next cycle IDLE, all strobes 0, pending writes discarded, no end_.
REQ-028 abort and start in the same IDLE cycle: abort wins; start ignored.
REQ-029 Write-side delay line SHALL be a PIPE_LAT-deep shift of ub_rd_valid; no FIFO pop or reload for tile k+1 before tile k's last write.

Reset
REQ-030 rst=1 SHALL asynchronously force IDLE, all counters/pointers 0, every output 0.
REQ-031 Reset mid-job SHALL discard the job; first post-reset start behaves as from power-up.

Structure
REQ-032 State encoding and PIPE_LAT default SHALL live in shared package tpu_pkg.
REQ-033 The result-timing delay line SHALL be a sub-module tpu_valid_delay (parameter DEPTH), reused by later blocks.

Verification
REQ-034 num_rows=8, num_tiles=1, src=0x010, dst=0x020, FIFO non-empty -> one pop, one we_rl, UB 0x010-0x017, writes 0x020-0x027 starting 17 cycles after first read, end_ once.
REQ-035 num_tiles=3, num_rows=4, src=0 -> three pops/reloads; reads 0-11 contiguous; writes contiguous; end_ after 12th write.
REQ-036 fifo_empty held 5 cycles after start -> busy=1, no pop until fifo_empty falls, then pop next cycle.
REQ-037 src_base=0x3FE, num_rows=4 -> reads 0x3FE,0x3FF,0x000,0x001.
REQ-038 start with num_rows=0 -> error pulse, busy stays 0; start during STREAM -> ignored.
REQ-039 abort in DRAIN, then rst mid-STREAM -> IDLE next cycle, no further res_write_enable, no end_; outputs 0 immediately on rst.
